// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, carry/zero/negative/overflow
// flags and a pass-through tag. Define ALU_SAT_EN to add in_sat (signed saturation on arithmetic overflow).
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef ALU_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
`ifdef ALU_SAT_EN
  logic             s1_sat;
`endif

  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] res_nx;
  logic             c_nx;
  logic             v_nx;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    r    = '0;
    c_nx = 1'b0;
    v_nx = 1'b0;
    case (s1_op)
      3'b000: begin
        r    = {1'b0, s1_a} + {1'b0, s1_b};
        c_nx = r[WIDTH];
        v_nx = (s1_a[MSB] == s1_b[MSB]) && (r[MSB] != s1_a[MSB]);
      end
      3'b001: begin
        r    = {1'b0, s1_a} - {1'b0, s1_b};
        c_nx = r[WIDTH];
        v_nx = (s1_a[MSB] != s1_b[MSB]) && (r[MSB] != s1_a[MSB]);
      end
      3'b010: begin
        r    = {1'b0, s1_b} - {1'b0, s1_a};
        c_nx = r[WIDTH];
        v_nx = (s1_a[MSB] != s1_b[MSB]) && (r[MSB] != s1_b[MSB]);
      end
      3'b011:  r = {1'b0, s1_a | s1_b};
      3'b100:  r = {1'b0, s1_a & s1_b};
      3'b101:  r = {1'b0, s1_a ^ s1_b};
      3'b110:  r = {1'b0, s1_a ~^ s1_b};
      default: r = '0;
    endcase
    res_nx = r[WIDTH-1:0];
`ifdef ALU_SAT_EN
    // v is only ever set by arithmetic ops; a wrapped negative sign means the true result overflowed upwards
    if (s1_sat && v_nx)
      res_nx = r[MSB] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_tag     <= '0;
`ifdef ALU_SAT_EN
      s1_sat     <= 1'b0;
`endif
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_c      <= 1'b0;
      out_z      <= 1'b0;
      out_n      <= 1'b0;
      out_v      <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a   <= in_a;
          s1_b   <= in_b;
          s1_op  <= in_op;
          s1_tag <= in_tag;
`ifdef ALU_SAT_EN
          s1_sat <= in_sat;
`endif
        end
      end
      // An empty stage 1 pushes a bubble; stage-2 data is left as-is since out_valid masks it
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res_nx;
          out_tag    <= s1_tag;
          out_c      <= c_nx;
          out_z      <= (res_nx == '0);
          out_n      <= res_nx[MSB];
          out_v      <= v_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8, TAG_W=4): scenario tasks with a scoreboard of
// expected results pushed on accept and popped on result transfer.
module tb_alu_pipe;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;

  typedef logic [WIDTH+TAG_W+3:0] res_t; // {result, tag, c, z, n, v}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_sat = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_c, out_z, out_n, out_v;

  int   vectors = 0;
  int   miscompares = 0;
  res_t sb[$];

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
`ifdef ALU_SAT_EN
    .in_sat(in_sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                 input logic [3:0] tag, input logic sat);
    int unsigned ua, ub;
    int          sa, sb_, t;
    logic [7:0]  res;
    logic        c, v;
    ua = a; ub = b;
    sa = $signed(a); sb_ = $signed(b);
    c = 1'b0; v = 1'b0; t = 0; res = 8'h00;
    case (op)
      3'd0: begin res = 8'(ua + ub); c = (ua + ub) > 255; t = sa + sb_; end
      3'd1: begin res = 8'(ua - ub); c = ua < ub;         t = sa - sb_; end
      3'd2: begin res = 8'(ub - ua); c = ub < ua;         t = sb_ - sa; end
      3'd3: res = a | b;
      3'd4: res = a & b;
      3'd5: res = a ^ b;
      3'd6: res = ~(a ^ b);
      default: res = 8'h00;
    endcase
    if (op <= 3'd2) v = (t > 127) || (t < -128);
`ifdef ALU_SAT_EN
    if (sat && v) res = (t > 127) ? 8'h7F : 8'h80;
`else
    if (sat) res = res; // saturation absent from this build
`endif
    return {res, tag, c, (res == 8'h00), res[7], v};
  endfunction

  // One clock of stimulus: drive at negedge, observe handshakes, record expected on accept.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input logic sat, input logic rdy,
                      output logic acc, output logic got, output res_t act);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag; in_sat = sat; out_ready = rdy;
    #1;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(model(a, b, op, tag, sat));
    got = out_valid && out_ready;
    act = {out_result, out_tag, out_c, out_z, out_n, out_v};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    vectors++;
    if ({out_valid, out_result, out_tag, out_c, out_z, out_n, out_v} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b r=%h t=%h c=%b z=%b n=%b v=%b required all 0",
               out_valid, out_result, out_tag, out_c, out_z, out_n, out_v);
    end
  endtask

  task automatic test_latency();
    logic acc, got; res_t act, exp;
    step(1, 8'hF0, 8'h20, 3'd0, 4'd3, 0, 1, acc, got, act);
    vectors++;
    if (!acc || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_accept: got acc=%b out_valid=%b required 1/0", acc, out_valid);
    end
    step(0, 0, 0, 0, 0, 0, 1, acc, got, act);
    vectors++;
    if (got !== 1'b0) begin
      miscompares++; $display("FAIL latency_early: got out_valid=%b required 0 one edge after accept", got);
    end
    step(0, 0, 0, 0, 0, 0, 1, acc, got, act);
    vectors++;
    if (got !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL latency_present: got out_valid=%b required 1 two edges after accept", got);
    end else begin
      exp = sb.pop_front();
      vectors++;
      if (act !== exp) begin
        miscompares++; $display("FAIL latency_result: got %h required %h", act, exp);
      end
    end
    sb.delete();
  endtask

  task automatic test_ops();
    logic [7:0] va[8]  = '{8'hF0, 8'h05, 8'h05, 8'h7F, 8'hFF, 8'hA5, 8'h80, 8'h3C};
    logic [7:0] vb[8]  = '{8'h20, 8'h07, 8'h07, 8'h01, 8'hFF, 8'h0F, 8'h01, 8'hC3};
    logic [2:0] vo[8]  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd7, 3'd3, 3'd1, 3'd6};
    logic       vs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic acc, got; res_t act, exp;
    int n;
`ifdef ALU_SAT_EN
    n = 10;
`else
    n = 8;
`endif
    for (int i = 0; i < n + 20 && (i < n || sb.size() > 0); i++) begin
      if (i < 8)
        step(1, va[i], vb[i], vo[i], 4'(i + 3), vs[i], 1, acc, got, act);
      else if (i == 8 && n == 10)
        step(1, 8'h7F, 8'h01, 3'd0, 4'hA, 1, 1, acc, got, act);
      else if (i == 9 && n == 10)
        step(1, 8'h80, 8'h01, 3'd1, 4'hB, 1, 1, acc, got, act);
      else
        step(0, 0, 0, 0, 0, 0, 1, acc, got, act);
      if (got) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL ops_unexpected: got %h required no result", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            miscompares++; $display("FAIL ops_result: got %h required %h", act, exp);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL ops_drain: got %0d results missing required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_backpressure();
    logic acc, got; res_t act, exp;
    step(1, 8'h10, 8'h01, 3'd0, 4'd1, 0, 0, acc, got, act);
    vectors++;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL bp_accept_tag1: got %b required 1", acc); end
    step(1, 8'h20, 8'h02, 3'd1, 4'd2, 0, 0, acc, got, act);
    vectors++;
    if (acc !== 1'b1) begin miscompares++; $display("FAIL bp_accept_tag2: got %b required 1", acc); end
    for (int k = 0; k < 2; k++) begin
      step(1, 8'h30, 8'h03, 3'd2, 4'd3, 0, 0, acc, got, act);
      vectors++;
      if (in_ready !== 1'b0 || got) begin
        miscompares++; $display("FAIL bp_stall: got in_ready=%b transfer=%b required 0/0", in_ready, got);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 8'h30, 8'h03, 3'd2, 4'd3, 0, 1, acc, got, act);
      vectors++;
      if (got !== (i < 3)) begin
        miscompares++; $display("FAIL bp_rate_cycle%0d: got out_valid=%b required %b", i, got, i < 3);
      end
      if (got) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL bp_duplicate: got %h required no result", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            miscompares++; $display("FAIL bp_order: got %h required %h", act, exp);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL bp_lost: got %0d results missing required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic acc, got; res_t act, exp;
    for (int i = 0; i < 30 && (i < 10 || sb.size() > 0); i++) begin
      if (i < 10) begin
        step(1, 8'(i * 29 + 7), 8'(i * 53 + 200), 3'(i), 4'(i), 0, 1, acc, got, act);
        vectors++;
        if (acc !== 1'b1) begin
          miscompares++; $display("FAIL b2b_in_ready_%0d: got %b required 1", i, acc);
        end
      end else begin
        step(0, 0, 0, 0, 0, 0, 1, acc, got, act);
      end
      if (got) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL b2b_unexpected: got %h required no result", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            miscompares++; $display("FAIL b2b_result: got %h required %h", act, exp);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL b2b_drain: got %0d results missing required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_random();
    logic acc, got; res_t act, exp;
    for (int i = 0; i < 140 && (i < 100 || sb.size() > 0); i++) begin
      if (i < 100)
        step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom),
             1'($urandom), ($urandom % 3) != 0, acc, got, act);
      else
        step(0, 0, 0, 0, 0, 0, 1, acc, got, act);
      if (got) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL rnd_unexpected: got %h required no result", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            miscompares++; $display("FAIL rnd_result: got %h required %h", act, exp);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL rnd_drain: got %0d results missing required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_in_flight();
    logic acc, got; res_t act;
    int seen;
    step(1, 8'h11, 8'h22, 3'd0, 4'd5, 0, 0, acc, got, act);
    step(1, 8'h33, 8'h44, 3'd5, 4'd6, 0, 0, acc, got, act);
    step(0, 0, 0, 0, 0, 0, 0, acc, got, act);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_flight_pre: got out_valid=%b required 1", out_valid);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_flight_drop: got out_valid=%b required 0", out_valid);
    end
    sb.delete();
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, acc, got, act);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL rst_flight_ghost: got %0d results after reset required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
